// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing types, 640x480 defaults and config helpers
package vga_timing_pkg;

  localparam int CW = 12;

  localparam int H_ACT_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_ACT_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

  typedef struct packed {
    logic [CW-1:0] act;
    logic [CW-1:0] fp;
    logic [CW-1:0] sync;
    logic [CW-1:0] bp;
  } timing_t;

  // Two guard bits so an oversized config is detected instead of wrapping.
  function automatic logic [CW+1:0] timing_sum(input timing_t t);
    return {2'b00, t.act} + {2'b00, t.fp} + {2'b00, t.sync} + {2'b00, t.bp};
  endfunction

  function automatic timing_t fix_zero(input timing_t t);
    timing_t r;
    r = t;
    if (r.act == '0) r.act = CW'(1);
    if (r.sync == '0) r.sync = CW'(1);
    return r;
  endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// rtl/vga_axis_fsm.sv - one axis of the timing generator: counter, phase FSM, phase-remaining count
module vga_axis_fsm
  import vga_timing_pkg::*;
#(
  parameter logic [CW-1:0] RST_ACT = CW'(H_ACT_DEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  timing_t       timing,
  input  timing_t       timing_next,
  output logic [CW-1:0] count,
  output logic [CW-1:0] nxt_count,
  output phase_t        nxt_phase,
  output logic          wrap
);

  phase_t        phase;
  logic [CW-1:0] rem;
  logic [CW-1:0] nxt_rem;
  logic [CW-1:0] last;

  assign last = CW'(timing_sum(timing) - 1);
  assign wrap = step && (count == last);

  // rem counts the cycles left in the current phase minus one.
  always_comb begin
    nxt_count = count;
    nxt_phase = phase;
    nxt_rem   = rem;
    if (wrap) begin
      nxt_count = '0;
      nxt_phase = PH_ACTIVE;
      nxt_rem   = timing_next.act - 1'b1;
    end else if (step) begin
      nxt_count = count + 1'b1;
      if (rem != '0) begin
        nxt_rem = rem - 1'b1;
      end else begin
        unique case (phase)
          PH_ACTIVE: begin
            if (timing.fp != '0) begin
              nxt_phase = PH_FRONT;
              nxt_rem   = timing.fp - 1'b1;
            end else begin
              nxt_phase = PH_SYNC;
              nxt_rem   = timing.sync - 1'b1;
            end
          end
          PH_FRONT: begin
            nxt_phase = PH_SYNC;
            nxt_rem   = timing.sync - 1'b1;
          end
          PH_SYNC: begin
            if (timing.bp != '0) begin
              nxt_phase = PH_BACK;
              nxt_rem   = timing.bp - 1'b1;
            end else begin
              nxt_phase = PH_ACTIVE;
              nxt_rem   = timing.act - 1'b1;
            end
          end
          PH_BACK: begin
            nxt_phase = PH_ACTIVE;
            nxt_rem   = timing.act - 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      phase <= PH_ACTIVE;
      rem   <= RST_ACT - 1'b1;
    end else begin
      count <= nxt_count;
      phase <= nxt_phase;
      rem   <= nxt_rem;
    end
  end

endmodule

// File: rtl/vga_timing_controller.sv
// rtl/vga_timing_controller.sv - VGA sync/timing generator with frame-boundary reconfiguration
// Optional per-axis sync polarity inputs are enabled by defining VGA_TIMING_SYNC_POL_EN.
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int H_ACT  = H_ACT_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_ACT  = V_ACT_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic          clk_25MHz,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_h_act,
  input  logic [CW-1:0] cfg_h_fp,
  input  logic [CW-1:0] cfg_h_sync,
  input  logic [CW-1:0] cfg_h_bp,
  input  logic [CW-1:0] cfg_v_act,
  input  logic [CW-1:0] cfg_v_fp,
  input  logic [CW-1:0] cfg_v_sync,
  input  logic [CW-1:0] cfg_v_bp,
`ifdef VGA_TIMING_SYNC_POL_EN
  input  logic          cfg_hpol,
  input  logic          cfg_vpol,
`endif
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          line_end,
  output logic          frame_start
);

  localparam timing_t H_DEF = '{act: CW'(H_ACT), fp: CW'(H_FP), sync: CW'(H_SYNC), bp: CW'(H_BP)};
  localparam timing_t V_DEF = '{act: CW'(V_ACT), fp: CW'(V_FP), sync: CW'(V_SYNC), bp: CW'(V_BP)};
  localparam logic [CW+1:0] SUM_MAX = {2'b00, {CW{1'b1}}};

  timing_t       h_tim, v_tim, h_pend, v_pend, h_next, v_next, h_fix, v_fix;
  logic          take, apply, h_wrap, v_wrap, vid_next, h_pol_next, v_pol_next;
  logic [CW-1:0] nxt_h, nxt_v;
  phase_t        nxt_hph, nxt_vph;

  assign h_fix    = fix_zero(timing_t'({cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp}));
  assign v_fix    = fix_zero(timing_t'({cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp}));
  assign take     = cfg_valid && cfg_ready &&
                    (timing_sum(h_fix) <= SUM_MAX) && (timing_sum(v_fix) <= SUM_MAX);
  // The last cycle of the frame is the only point where new timing may take effect.
  assign apply    = !cfg_ready && v_wrap;
  assign h_next   = apply ? h_pend : h_tim;
  assign v_next   = apply ? v_pend : v_tim;
  assign vid_next = (nxt_hph == PH_ACTIVE) && (nxt_vph == PH_ACTIVE);

  vga_axis_fsm #(.RST_ACT(H_DEF.act)) u_h_axis (
    .clk         (clk_25MHz),
    .rst_n       (rst_n),
    .step        (1'b1),
    .timing      (h_tim),
    .timing_next (h_next),
    .count       (h_count),
    .nxt_count   (nxt_h),
    .nxt_phase   (nxt_hph),
    .wrap        (h_wrap)
  );

  vga_axis_fsm #(.RST_ACT(V_DEF.act)) u_v_axis (
    .clk         (clk_25MHz),
    .rst_n       (rst_n),
    .step        (h_wrap),
    .timing      (v_tim),
    .timing_next (v_next),
    .count       (v_count),
    .nxt_count   (nxt_v),
    .nxt_phase   (nxt_vph),
    .wrap        (v_wrap)
  );

`ifdef VGA_TIMING_SYNC_POL_EN
  logic h_pol, v_pol, h_pol_pend, v_pol_pend;

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      h_pol      <= 1'b0;
      v_pol      <= 1'b0;
      h_pol_pend <= 1'b0;
      v_pol_pend <= 1'b0;
    end else if (apply) begin
      h_pol <= h_pol_pend;
      v_pol <= v_pol_pend;
    end else if (take) begin
      h_pol_pend <= cfg_hpol;
      v_pol_pend <= cfg_vpol;
    end
  end

  assign h_pol_next = apply ? h_pol_pend : h_pol;
  assign v_pol_next = apply ? v_pol_pend : v_pol;
`else
  assign h_pol_next = 1'b0;
  assign v_pol_next = 1'b0;
`endif

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      h_tim     <= H_DEF;
      v_tim     <= V_DEF;
      h_pend    <= H_DEF;
      v_pend    <= V_DEF;
      cfg_ready <= 1'b1;
    end else if (apply) begin
      h_tim     <= h_pend;
      v_tim     <= v_pend;
      cfg_ready <= 1'b1;
    end else if (take) begin
      h_pend    <= h_fix;
      v_pend    <= v_fix;
      cfg_ready <= 1'b0;
    end
  end

  // Outputs are computed from next-state so they line up with the counters.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b1;
      pixel_x     <= '0;
      pixel_y     <= '0;
    end else begin
      hsync       <= (nxt_hph == PH_SYNC) == h_pol_next;
      vsync       <= (nxt_vph == PH_SYNC) == v_pol_next;
      video_on    <= vid_next;
      line_end    <= nxt_h == CW'(timing_sum(h_next) - 1);
      frame_start <= (nxt_h == '0) && (nxt_v == '0);
      pixel_x     <= vid_next ? nxt_h : '0;
      pixel_y     <= vid_next ? nxt_v : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_controller.sv
// tb/tb_vga_timing_controller.sv - scoreboard bench for vga_timing_controller on a reduced default raster
module tb_vga_timing_controller;

  localparam int CW = 12;

  typedef struct {
    int act;
    int fp;
    int sync;
    int bp;
  } tim_t;

  typedef struct packed {
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic          line_end;
    logic          frame_start;
    logic          cfg_ready;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
  } obs_t;

  logic          clk_25MHz = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_h_act = '0, cfg_h_fp = '0, cfg_h_sync = '0, cfg_h_bp = '0;
  logic [CW-1:0] cfg_v_act = '0, cfg_v_fp = '0, cfg_v_sync = '0, cfg_v_bp = '0;
  logic          hsync, vsync, video_on, line_end, frame_start;
  logic [CW-1:0] pixel_x, pixel_y, h_count, v_count;

  always #20 clk_25MHz = ~clk_25MHz;

  vga_timing_controller #(
    .H_ACT(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACT(8),  .V_FP(2), .V_SYNC(2), .V_BP(4)
  ) dut (
    .clk_25MHz   (clk_25MHz),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_h_act   (cfg_h_act),
    .cfg_h_fp    (cfg_h_fp),
    .cfg_h_sync  (cfg_h_sync),
    .cfg_h_bp    (cfg_h_bp),
    .cfg_v_act   (cfg_v_act),
    .cfg_v_fp    (cfg_v_fp),
    .cfg_v_sync  (cfg_v_sync),
    .cfg_v_bp    (cfg_v_bp),
`ifdef VGA_TIMING_SYNC_POL_EN
    .cfg_hpol    (1'b0),
    .cfg_vpol    (1'b0),
`endif
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .h_count     (h_count),
    .v_count     (v_count),
    .line_end    (line_end),
    .frame_start (frame_start)
  );

  int    tests = 0;
  int    fails = 0;
  tim_t  cur_h, cur_v, pend_h, pend_v;
  int    mh, mv;
  bit    m_rdy, first;
  obs_t  sb[$];
  string step_tag;

  function automatic int tot(input tim_t t);
    return t.act + t.fp + t.sync + t.bp;
  endfunction

  // Reference: phase is derived from the counter position, not from a state machine.
  function automatic obs_t expect_now();
    obs_t e;
    int hs, vs;
    hs = cur_h.act + cur_h.fp;
    vs = cur_v.act + cur_v.fp;
    e.hsync       = !(mh >= hs && mh < hs + cur_h.sync);
    e.vsync       = !(mv >= vs && mv < vs + cur_v.sync);
    e.video_on    = (mh < cur_h.act) && (mv < cur_v.act) && !first;
    e.line_end    = (mh == tot(cur_h) - 1) && !first;
    e.frame_start = (mh == 0) && (mv == 0);
    e.cfg_ready   = m_rdy;
    e.pixel_x     = e.video_on ? CW'(mh) : '0;
    e.pixel_y     = e.video_on ? CW'(mv) : '0;
    e.h_count     = CW'(mh);
    e.v_count     = CW'(mv);
    return e;
  endfunction

  task automatic model_reset();
    cur_h = '{16, 4, 6, 6};
    cur_v = '{8, 2, 2, 4};
    mh    = 0;
    mv    = 0;
    m_rdy = 1'b1;
    first = 1'b1;
  endtask

  task automatic model_edge();
    bit   do_apply;
    tim_t fh, fv;
    do_apply = !m_rdy && (mh == tot(cur_h) - 1) && (mv == tot(cur_v) - 1);
    if (m_rdy && cfg_valid) begin
      fh = '{int'(cfg_h_act), int'(cfg_h_fp), int'(cfg_h_sync), int'(cfg_h_bp)};
      fv = '{int'(cfg_v_act), int'(cfg_v_fp), int'(cfg_v_sync), int'(cfg_v_bp)};
      if (fh.act == 0) fh.act = 1;
      if (fh.sync == 0) fh.sync = 1;
      if (fv.act == 0) fv.act = 1;
      if (fv.sync == 0) fv.sync = 1;
      if (tot(fh) <= 4095 && tot(fv) <= 4095) begin
        pend_h = fh;
        pend_v = fv;
        m_rdy  = 1'b0;
      end
    end
    if (mh == tot(cur_h) - 1) begin
      mh = 0;
      mv = (mv == tot(cur_v) - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    if (do_apply) begin
      cur_h = pend_h;
      cur_v = pend_v;
      m_rdy = 1'b1;
    end
    first = 1'b0;
  endtask

  task automatic compare_head();
    obs_t o, e;
    o = {hsync, vsync, video_on, line_end, frame_start, cfg_ready, pixel_x, pixel_y, h_count, v_count};
    e = sb.pop_front();
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s h=%0d v=%0d observed=%h expected=%h", step_tag, mh, mv, o, e);
    end
  endtask

  task automatic check_now();
    sb.push_back(expect_now());
    compare_head();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      model_edge();
      sb.push_back(expect_now());
      @(negedge clk_25MHz);
      compare_head();
    end
  endtask

  task automatic offer(input int ha, input int hf, input int hs, input int hb,
                       input int va, input int vf, input int vs, input int vb);
    cfg_h_act = CW'(ha); cfg_h_fp = CW'(hf); cfg_h_sync = CW'(hs); cfg_h_bp = CW'(hb);
    cfg_v_act = CW'(va); cfg_v_fp = CW'(vf); cfg_v_sync = CW'(vs); cfg_v_bp = CW'(vb);
    cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    step_tag = "reset";
    model_reset();
    repeat (3) @(negedge clk_25MHz);
    check_now();
    rst_n = 1'b1;
    check_now();

    step_tag = "dflt";
    tick(1100);

    step_tag = "cfg";
    tick(100);
    offer(20, 2, 3, 5, 10, 1, 2, 3);
    tick(1100);

    step_tag = "zero_porch";
    offer(10, 0, 4, 0, 6, 0, 2, 0);
    tick(800);

    step_tag = "overflow";
    offer(4000, 40, 50, 10, 8, 2, 2, 4);
    tick(300);

    step_tag = "zero_fix";
    offer(0, 3, 0, 2, 4, 1, 1, 1);
    tick(400);

    step_tag = "rst_pend";
    for (int i = 0; i < 100 && !(mh == 2 && mv == 1); i++) tick(1);
    offer(30, 2, 2, 2, 10, 2, 2, 2);
    tick(3);
    offer(12, 1, 1, 1, 6, 1, 1, 1);
    tick(3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_now();
    @(negedge clk_25MHz);
    check_now();
    rst_n = 1'b1;
    check_now();
    step_tag = "post_rst";
    tick(1100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
